// File: rtl/alu_chk_pkg.sv
// Shared types and the compare rule for the ALU result checker.
package alu_chk_pkg;

    localparam int unsigned DATA_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic                  overflow;
        logic [DATA_W_DEF-1:0] data;
    } exp_entry_t;

    // Overflow must always agree; data only matters when no overflow is expected.
    function automatic logic result_mismatch(input exp_entry_t exp, input exp_entry_t res);
        return (res.overflow != exp.overflow) ||
               (!exp.overflow && (res.data != exp.data));
    endfunction

endpackage

// File: rtl/alu_chk_fifo.sv
// Synchronous FIFO of expected entries with synchronous flush.
module alu_chk_fifo #(
    parameter int unsigned W     = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/alu_result_checker.sv
// On-chip checker for the ALU result stream: queues expected results and counts mismatches.
// Optional watchdog enabled by `define ALU_CHK_TIMEOUT_EN (adds TIMEOUT_CYC and o_timeout).
module alu_result_checker
    import alu_chk_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
`ifdef ALU_CHK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_pat_num,
    input  logic              i_exp_valid,
    input  logic [DATA_W-1:0] i_exp_data,
    input  logic              i_exp_overflow,
    output logic              o_exp_ready,
    input  logic              i_res_valid,
    input  logic [DATA_W-1:0] i_res_data,
    input  logic              i_res_overflow,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_err_pulse,
    output logic [CNT_W-1:0]  o_err_cnt
`ifdef ALU_CHK_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] pat_q;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_pulse;
    logic             start_acc;
    logic             res_fire;
    logic             last_res;
    logic             mismatch;
    logic             push;
    logic             full;
    logic             empty;
    exp_entry_t       push_entry;
    exp_entry_t       head;
    exp_entry_t       res_entry;
    logic             timed_out;

    assign start_acc = i_start && (state != RUN);
    assign res_fire  = (state == RUN) && i_res_valid;
    assign last_res  = (chk_cnt + CNT_W'(1)) == pat_q;
    assign push      = i_exp_valid && o_exp_ready;

    assign push_entry.overflow = i_exp_overflow;
    assign push_entry.data     = DATA_W_DEF'(i_exp_data);
    assign res_entry.overflow  = i_res_overflow;
    assign res_entry.data      = DATA_W_DEF'(i_res_data);

    // An orphan result (nothing queued) is always an error.
    assign mismatch = empty ? 1'b1 : result_mismatch(head, res_entry);

    alu_chk_fifo #(
        .W     ($bits(exp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (start_acc),
        .push      (push),
        .push_data (push_entry),
        .pop       (res_fire),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

`ifdef ALU_CHK_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            timeout_q;

    assign wd_expire = (state == RUN) && !i_res_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign timed_out = timeout_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (start_acc) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state == RUN) begin
            if (i_res_valid)    wd_cnt    <= '0;
            else if (wd_expire) timeout_q <= 1'b1;
            else                wd_cnt    <= wd_cnt + 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic wd_expire;

    assign wd_expire = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (i_start) state_n = (i_pat_num == '0) ? DONE : RUN;
            end
            RUN: begin
                if (res_fire && last_res) state_n = DONE;
                else if (wd_expire)       state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pat_q     <= '0;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= res_fire && mismatch;
            if (start_acc) begin
                pat_q   <= i_pat_num;
                chk_cnt <= '0;
                err_cnt <= '0;
            end else if (res_fire) begin
                chk_cnt <= chk_cnt + CNT_W'(1);
                if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_busy      = (state == RUN);
        o_done      = (state == DONE);
        o_pass      = (state == DONE) && (err_cnt == '0) && !timed_out;
        o_exp_ready = (state == RUN) && !full;
        o_err_pulse = err_pulse;
        o_err_cnt   = err_cnt;
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed, table-driven bench for alu_result_checker.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pat_num;
    logic        exp_valid;
    logic [11:0] exp_data;
    logic        exp_ovf;
    logic        exp_ready;
    logic        res_valid;
    logic [11:0] res_data;
    logic        res_ovf;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err_pulse;
    logic [15:0] err_cnt;
`ifdef ALU_CHK_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_checker #(
        .DATA_W (12),
        .DEPTH  (8),
        .CNT_W  (16)
`ifdef ALU_CHK_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (20)
`endif
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_pat_num      (pat_num),
        .i_exp_valid    (exp_valid),
        .i_exp_data     (exp_data),
        .i_exp_overflow (exp_ovf),
        .o_exp_ready    (exp_ready),
        .i_res_valid    (res_valid),
        .i_res_data     (res_data),
        .i_res_overflow (res_ovf),
        .o_busy         (busy),
        .o_done         (done),
        .o_pass         (pass),
        .o_err_pulse    (err_pulse),
        .o_err_cnt      (err_cnt)
`ifdef ALU_CHK_TIMEOUT_EN
        ,
        .o_timeout      (timeout)
`endif
    );

    typedef struct {
        logic        eo;
        logic [11:0] ed;
        logic        ro;
        logic [11:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start   = 1'b1;
        pat_num = 16'(n);
        step();
        start = 1'b0;
    endtask

    task automatic do_push(input logic o, input logic [11:0] d);
        exp_valid = 1'b1;
        exp_ovf   = o;
        exp_data  = d;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic do_result(input logic o, input logic [11:0] d);
        res_valid = 1'b1;
        res_ovf   = o;
        res_data  = d;
        step();
        res_valid = 1'b0;
    endtask

    task automatic run_group(input int first, input int n);
        int exp_errs;
        exp_errs = 0;
        do_start(n);
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(exp_ready), 1);
        for (int i = first; i < first + n; i++) begin
            do_push(vecs[i].eo, vecs[i].ed);
            do_result(vecs[i].ro, vecs[i].rd);
            if (vecs[i].err) exp_errs++;
            chk($sformatf("v%0d_pulse", i), 32'(err_pulse), 32'(vecs[i].err));
            chk($sformatf("v%0d_errcnt", i), 32'(err_cnt), 32'(exp_errs));
            chk($sformatf("v%0d_done", i), 32'(done), (i == first + n - 1) ? 1 : 0);
        end
        chk("grp_pass", 32'(pass), (exp_errs == 0) ? 1 : 0);
        chk("grp_busy", 32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{eo: 1'b0, ed: 12'h020, ro: 1'b0, rd: 12'h020, err: 1'b0};
        vecs[1] = '{eo: 1'b0, ed: 12'hFE0, ro: 1'b0, rd: 12'hFE0, err: 1'b0};
        vecs[2] = '{eo: 1'b1, ed: 12'h000, ro: 1'b1, rd: 12'h7FF, err: 1'b0};
        vecs[3] = '{eo: 1'b0, ed: 12'h040, ro: 1'b0, rd: 12'h041, err: 1'b1};
        vecs[4] = '{eo: 1'b0, ed: 12'h040, ro: 1'b1, rd: 12'h040, err: 1'b1};
        vecs[5] = '{eo: 1'b1, ed: 12'h123, ro: 1'b0, rd: 12'h123, err: 1'b1};
        vecs[6] = '{eo: 1'b0, ed: 12'h7FF, ro: 1'b0, rd: 12'h7FF, err: 1'b0};

        rst = 1'b1; start = 1'b0; pat_num = '0;
        exp_valid = 1'b0; exp_data = '0; exp_ovf = 1'b0;
        res_valid = 1'b0; res_data = '0; res_ovf = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        chk("rst_ready", 32'(exp_ready), 0);
        rst = 1'b0;
        step();

        run_group(0, 3);
        run_group(3, 2);
        run_group(5, 2);

        // Result while DONE is ignored.
        do_result(1'b1, 12'h555);
        chk("done_ignore_pulse", 32'(err_pulse), 0);
        chk("done_ignore_cnt", 32'(err_cnt), 1);

        // pat_num = 0 finishes immediately with pass.
        do_start(0);
        chk("zero_done", 32'(done), 1);
        chk("zero_pass", 32'(pass), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_errcnt", 32'(err_cnt), 0);

        // Queue full / drop / refill: 11 entries 0x100+k, 11 results.
        do_start(11);
        for (int k = 0; k < 8; k++) do_push(1'b0, 12'(12'h100 + k));
        chk("full_ready", 32'(exp_ready), 0);
        exp_valid = 1'b1; exp_ovf = 1'b0; exp_data = 12'h108;
        step();
        step();
        chk("full_drop_ready", 32'(exp_ready), 0);
        do_result(1'b0, 12'h100);               // pop while offer held and not ready
        chk("pop0_pulse", 32'(err_pulse), 0);
        chk("pop0_ready", 32'(exp_ready), 1);
        exp_valid = 1'b1;
        step();                                 // 9th entry accepted now
        exp_valid = 1'b0;
        chk("ninth_full", 32'(exp_ready), 0);
        do_result(1'b0, 12'h101);
        chk("pop1_ready", 32'(exp_ready), 1);
        exp_valid = 1'b1; exp_data = 12'h109;   // push + pop together at occupancy 7
        res_valid = 1'b1; res_ovf = 1'b0; res_data = 12'h102;
        step();
        exp_valid = 1'b0; res_valid = 1'b0;
        chk("pushpop_ready", 32'(exp_ready), 1);
        chk("pushpop_pulse", 32'(err_pulse), 0);
        do_push(1'b0, 12'h10A);
        chk("refill_full", 32'(exp_ready), 0);
        for (int k = 3; k < 11; k++) begin
            do_result(1'b0, 12'(12'h100 + k));
            chk($sformatf("drain%0d_pulse", k), 32'(err_pulse), 0);
        end
        chk("drain_done", 32'(done), 1);
        chk("drain_pass", 32'(pass), 1);
        chk("drain_errcnt", 32'(err_cnt), 0);

        // Orphan result.
        do_start(1);
        do_result(1'b0, 12'h000);
        chk("orphan_pulse", 32'(err_pulse), 1);
        chk("orphan_errcnt", 32'(err_cnt), 1);
        chk("orphan_done", 32'(done), 1);
        chk("orphan_pass", 32'(pass), 0);

        // Start during RUN is ignored; reset mid-run clears everything.
        do_start(5);
        do_push(1'b0, 12'h011);
        do_push(1'b0, 12'h022);
        do_result(1'b0, 12'h011);
        do_start(1);
        chk("run_start_ignored", 32'(busy), 1);
        do_result(1'b0, 12'h023);
        chk("mid_errcnt", 32'(err_cnt), 1);
        chk("mid_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_pass", 32'(pass), 0);
        chk("arst_pulse", 32'(err_pulse), 0);
        chk("arst_errcnt", 32'(err_cnt), 0);
        chk("arst_ready", 32'(exp_ready), 0);
        step();
        rst = 1'b0;
        step();
        do_start(1);
        do_push(1'b0, 12'h3C5);
        do_result(1'b0, 12'h3C5);
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_pass", 32'(pass), 1);

`ifdef ALU_CHK_TIMEOUT_EN
        do_start(1);
        for (int c = 0; c < 19; c++) step();
        chk("wd_not_yet", 32'(done), 0);
        step();
        chk("wd_timeout", 32'(timeout), 1);
        chk("wd_done", 32'(done), 1);
        chk("wd_pass", 32'(pass), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
